reg_pipeline: RTL and testbench

REG_PIPELINE -- requirements
Module: reg_pipeline

---
 rtl/reg_pipeline.sv | 84 ++++++++
 tb/tb_reg_pipeline.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/reg_pipeline.sv
// rtl/reg_pipeline.sv - DEPTH-stage valid/ready register pipeline with bubble compression,
// flush, and an occupancy count.
module reg_pipeline #(
  parameter int               WIDTH     = 12,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] adv;
  logic [CW-1:0]    count_q, count_d;
  logic             clear, accept, emit;

  // A stage may load when it is empty or when its own word moves on downstream,
  // so an empty slot anywhere ahead lets everything behind it close the gap.
  always_comb begin : adv_chain
    logic ready_c;
    ready_c = out_ready;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      ready_c = ready_c | ~valid_q[k];
      adv[k]  = ready_c;
    end
  end

  assign clear    = rst | flush;
  assign in_ready = adv[0] & ~clear;
  assign accept   = in_valid & in_ready;
  assign emit     = valid_q[DEPTH-1] & out_ready & ~clear;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    count_d = count_q + CW'(accept) - CW'(emit);
    if (clear) begin
      valid_d = '0;
      count_d = '0;
      for (int k = 0; k < DEPTH; k++) begin
        data_d[k] = RESET_VAL;
      end
    end else begin
      // Data only moves with a valid word; bubbles leave stale data in place.
      if (adv[0]) begin
        valid_d[0] = accept;
        if (accept) begin
          data_d[0] = in_data;
        end
      end
      for (int k = 1; k < DEPTH; k++) begin
        if (adv[k]) begin
          valid_d[k] = valid_q[k-1];
          if (valid_q[k-1]) begin
            data_d[k] = data_q[k-1];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    valid_q <= valid_d;
    data_q  <= data_d;
    count_q <= count_d;
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];
  assign count     = count_q;

endmodule

// File: tb/tb_reg_pipeline.sv
// tb/tb_reg_pipeline.sv - scoreboard bench for reg_pipeline against a slot-position
// reference model.
module tb_reg_pipeline;

  localparam int W = 12;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready = 1'b0;
  logic [2:0]   count;

  int n_cmp = 0;
  int n_fail = 0;

  // Model: one slot index per word in flight (oldest first) plus the expected data.
  int           mpos[$];
  logic [W-1:0] sb[$];

  reg_pipeline #(.WIDTH(W), .DEPTH(D), .RESET_VAL('0)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Words slide toward the last slot, never passing the word ahead; the oldest
  // leaves from the last slot when out_ready is high. New words need slot 0 free.
  function automatic bit model_ready();
    int lim;
    int np;
    if (rst || flush) return 1'b0;
    lim = D - 1;
    for (int i = 0; i < mpos.size(); i++) begin
      if (i == 0 && mpos[0] == D - 1 && out_ready) continue;
      np  = (mpos[i] + 1 < lim) ? mpos[i] + 1 : lim;
      lim = np - 1;
    end
    return lim >= 0;
  endfunction

  function automatic void model_step();
    bit acc;
    int lim;
    int np;
    if (rst || flush) begin
      mpos.delete();
      sb.delete();
      return;
    end
    acc = in_valid && model_ready();
    if (mpos.size() > 0 && mpos[0] == D - 1 && out_ready) void'(mpos.pop_front());
    lim = D - 1;
    foreach (mpos[i]) begin
      np      = (mpos[i] + 1 < lim) ? mpos[i] + 1 : lim;
      mpos[i] = np;
      lim     = np - 1;
    end
    if (acc) begin
      mpos.push_back(0);
      sb.push_back(in_data);
    end
  endfunction

  task automatic cyc(input bit iv, input logic [W-1:0] id, input bit ordy, input bit fl, input bit rs);
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
    rst       = rs;
    @(negedge clk);
    chk("in_ready", 64'(in_ready), 64'(model_ready()));
    chk("out_valid", 64'(out_valid), 64'(mpos.size() > 0 && mpos[0] == D - 1));
    chk("count", 64'(count), 64'(mpos.size()));
    @(posedge clk);
    model_step();
    #1;
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0 && flush === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL out_extra: got 0x%0h expected no word", out_data);
      end else begin
        chk("out_data", 64'(out_data), 64'(sb.pop_front()));
      end
    end
  end

  initial begin
    rst = 1'b1;
    @(posedge clk);
    #1;

    cyc(1'b1, 12'hABC, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 12'hABC, 1'b1, 1'b0, 1'b1);
    chk("rst_data", 64'(out_data), 64'h0);
    chk("rst_valid", 64'(out_valid), 64'h0);

    for (int i = 1; i <= 8; i++) cyc(1'b1, W'(i), 1'b1, 1'b0, 1'b0);
    repeat (6) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 5; i++) cyc(1'b1, W'(12'h011 + i), 1'b0, 1'b0, 1'b0);
    chk("bp_count", 64'(count), 64'd4);
    cyc(1'b1, 12'h015, 1'b1, 1'b0, 1'b0);
    repeat (6) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);

    cyc(1'b1, 12'h0A1, 1'b1, 1'b0, 1'b0);
    repeat (2) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 12'h0A2, 1'b1, 1'b0, 1'b0);
    repeat (6) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 3; i++) cyc(1'b1, W'(12'h031 + i), 1'b0, 1'b0, 1'b0);
    chk("pre_flush_count", 64'(count), 64'd3);
    cyc(1'b1, 12'h777, 1'b1, 1'b1, 1'b0);
    chk("flush_data", 64'(out_data), 64'h0);
    chk("flush_valid", 64'(out_valid), 64'h0);
    chk("flush_count", 64'(count), 64'h0);
    repeat (6) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);

    repeat (10000) begin
      cyc($urandom_range(0, 99) < 30, W'($urandom), $urandom_range(0, 99) < 60,
          $urandom_range(0, 99) < 2, 1'b0);
    end
    repeat (8) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("drained", 64'(sb.size()), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
